note_phase_gen: RTL
===================

// Module: note_phase_gen
// PURPOSE
//  Multi-voice tone phase generator. Converts per-voice note numbers to integer+fractional
//  phase steps and accumulates a wavetable phase per voice on every sample tick.
//  Time-multiplexed: one shared adder updates voices 0..VOICES-1 in consecutive cycles.
//  Sits between the note/keyboard control logic and the wavetable readout/mixer.
// PARAMETERS
//  VOICES    4            number of independent voices (1..16)
//  PHASE_W   8            wavetable phase width; phase wraps modulo 2^PHASE_W
//  FRAC_W    27           fractional accumulator width
//  FRAC_MOD  100_000_000  fractional modulus; a carry of 1 into phase when frac >= FRAC_MOD
//  NOTE_W    5            note number width; valid notes 0..23
// PORTS
//  clk          in   1                 system clock
//  rst_n        in   1                 async active-low reset
//  tick         in   1                 sample strobe, 1-cycle pulse
//  note_wr      in   1                 write strobe for the voice note register
//  note_voice   in   clog2(VOICES)     target voice of note_wr
//  note_value   in   NOTE_W            note number 0..23
//  note_gate    in   1                 1 = voice active, 0 = voice frozen
//  phase        out  VOICES*PHASE_W    packed voice phases, voice 0 in LSBs
//  active       out  VOICES            per-voice gate and valid-note flag
//  busy         out  1                 sequencer is updating voices
//  done         out  1                 1-cycle pulse after the last voice update
//  overrun      out  1                 sticky: tick arrived while busy
// BEHAVIOUR
//  Reset, async: phase=0, frac=0, note regs=0, gates=0, active=0, busy=0, done=0,
//   overrun=0, sequencer IDLE.
//  Step table, combinational, in the package. Maps note n to jump (6b) and remainder
//   (<FRAC_MOD). Notes >= 24 give jump=0 and remainder=0. Anchors: n=9 gives 28/16_000_000;
//   n=21 gives 56/32_000_000; n=23 gives 63/21_706_256.
//  FSM IDLE -> RUN -> DONE -> IDLE:
//   IDLE: tick at edge 0 moves to RUN with idx=0. busy=1 from edge 0 on.
//   RUN: at edge k (k=1..VOICES), update voice k-1; after the last voice, go to DONE.
//   DONE: done=1 for exactly one cycle, busy=0; next state IDLE.
//  Voice update:
//   f = frac + remainder, using FRAC_W+1 bits.
//   c = (f >= FRAC_MOD); frac <= c ? f-FRAC_MOD : f.
//   phase <= (phase + jump + c) mod 2^PHASE_W.
//   If the gate is 0 or the note is >= 24, phase and frac hold.
//  active[v] = gate[v] && note[v] < 24. Updated on the cycle after the write.
//  Note write: takes effect at the next edge. If the write hits the voice being updated in
//   that same cycle, the update uses the old note; the new note applies from the next tick.
//  Tick while busy or in DONE: tick is ignored, overrun is set to 1 and stays set until reset.
//  Reset mid-sweep: all state returns to reset values at once; no done pulse.
// CONFIGURATION
//  HARD_SYNC_EN defined: a note_wr with note_gate=1 also clears that voice's phase and frac
//   at the same edge. This overrides any same-cycle update of that voice.
//  HARD_SYNC_EN undefined: phase and frac carry on across note changes (glitch-free legato).
// STRUCTURE
//  Package note_phase_pkg holds:
//   - FRAC_MOD default, NUM_NOTES=24
//   - step_t struct {jump[5:0], remainder[26:0]}
//   - function note_step(note) returning step_t
//  Sub-module phase_step_alu: combinational frac/carry/phase adder, instantiated once
//   and shared by all voices.
// TESTING
//  1 Reset: release rst_n -> phase=0, active=0, busy=0, done=0, overrun=0.
//  2 Voice 0 at note 9, gate=1, 7 ticks:
//     after 6 ticks -> phase=168, frac=96_000_000;
//     after tick 7 -> phase=197, frac=12_000_000.
//  3 Voice 0 at note 23, 5 ticks:
//     tick 4 -> phase=252;
//     tick 5 -> carry, phase wraps to 60, frac=8_531_280.
//  4 VOICES=4, tick at edge 0 -> busy high edges 0..4, voice k updated at edge k+1,
//     done pulse after edge 4; a second tick at edge 2 -> overrun=1 and no extra sweep.
//  5 Note 30 or gate=0 on voice 1 -> active[1]=0, phase[1] unchanged over 3 ticks;
//     other voices keep advancing.
//  6 Assert rst_n=0 at edge 2 of a sweep -> all outputs at reset values and no done pulse;
//     HARD_SYNC_EN build: note_wr to a running voice -> its phase=0 next cycle.

Source files
------------

// File: rtl/note_phase_pkg.sv
// note_phase_pkg: shared types, constants and the note-to-phase-step table for note_phase_gen.
package note_phase_pkg;

    localparam int FRAC_MOD_DEFAULT = 100_000_000;
    localparam int NUM_NOTES        = 24;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    typedef struct packed {
        logic [5:0]  jump;
        logic [26:0] remainder;
    } step_t;

    // Equal-tempered steps: 28.16 * 2^((n-9)/12), fraction in units of 1e-8, rounded to nearest.
    function automatic step_t note_step(input logic [4:0] note);
        case (note)
            5'd0:    return {6'd16, 27'd74_403_618};
            5'd1:    return {6'd17, 27'd73_968_838};
            5'd2:    return {6'd18, 27'd79_454_515};
            5'd3:    return {6'd19, 27'd91_212_696};
            5'd4:    return {6'd21, 27'd9_616_364};
            5'd5:    return {6'd22, 27'd35_060_681};
            5'd6:    return {6'd23, 27'd67_964_305};
            5'd7:    return {6'd25, 27'd8_770_790};
            5'd8:    return {6'd26, 27'd57_950_065};
            5'd9:    return {6'd28, 27'd16_000_000};
            5'd10:   return {6'd29, 27'd83_448_074};
            5'd11:   return {6'd31, 27'd60_853_128};
            5'd12:   return {6'd33, 27'd48_807_236};
            5'd13:   return {6'd35, 27'd47_937_677};
            5'd14:   return {6'd37, 27'd58_909_029};
            5'd15:   return {6'd39, 27'd82_425_392};
            5'd16:   return {6'd42, 27'd19_232_728};
            5'd17:   return {6'd44, 27'd70_121_362};
            5'd18:   return {6'd47, 27'd35_928_611};
            5'd19:   return {6'd50, 27'd17_541_581};
            5'd20:   return {6'd53, 27'd15_900_129};
            5'd21:   return {6'd56, 27'd32_000_000};
            5'd22:   return {6'd59, 27'd66_896_147};
            5'd23:   return {6'd63, 27'd21_706_256};
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/phase_step_alu.sv
// phase_step_alu: advances one voice's phase/fraction pair by a step, carrying when frac reaches FRAC_MOD.
module phase_step_alu
    import note_phase_pkg::*;
#(
    parameter int PHASE_W  = 8,
    parameter int FRAC_W   = 27,
    parameter int FRAC_MOD = FRAC_MOD_DEFAULT
)(
    input  logic [PHASE_W-1:0] phase_i,
    input  logic [FRAC_W-1:0]  frac_i,
    input  step_t              step_i,
    output logic [PHASE_W-1:0] phase_o,
    output logic [FRAC_W-1:0]  frac_o
);
    logic [FRAC_W:0] sum;
    logic            carry;

    assign sum     = {1'b0, frac_i} + {1'b0, FRAC_W'(step_i.remainder)};
    assign carry   = sum >= (FRAC_W+1)'(FRAC_MOD);
    assign frac_o  = FRAC_W'(carry ? sum - (FRAC_W+1)'(FRAC_MOD) : sum);
    assign phase_o = phase_i + PHASE_W'(step_i.jump) + PHASE_W'(carry);

endmodule

// File: rtl/note_phase_gen.sv
// note_phase_gen: multi-voice phase accumulator, one shared adder swept over the voices per tick.
// Define HARD_SYNC_EN to clear a voice's phase/frac whenever it is written with gate high.
module note_phase_gen
    import note_phase_pkg::*;
#(
    parameter int  VOICES   = 4,
    parameter int  PHASE_W  = 8,
    parameter int  FRAC_W   = 27,
    parameter int  FRAC_MOD = FRAC_MOD_DEFAULT,
    parameter int  NOTE_W   = 5,
    localparam int IW       = (VOICES > 1) ? $clog2(VOICES) : 1
)(
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      tick,
    input  logic                      note_wr,
    input  logic [IW-1:0]             note_voice,
    input  logic [NOTE_W-1:0]         note_value,
    input  logic                      note_gate,
    output logic [VOICES*PHASE_W-1:0] phase,
    output logic [VOICES-1:0]         active,
    output logic                      busy,
    output logic                      done,
    output logic                      overrun
);
    seq_state_t                     state_q, state_d;
    logic [IW-1:0]                  idx_q, idx_d;
    logic [VOICES-1:0][PHASE_W-1:0] phase_q, phase_d;
    logic [VOICES-1:0][FRAC_W-1:0]  frac_q, frac_d;
    logic [VOICES-1:0][NOTE_W-1:0]  note_q, note_d;
    logic [VOICES-1:0]              gate_q, gate_d;
    logic                           overrun_q, overrun_d;
    step_t                          st;
    logic [PHASE_W-1:0]             alu_phase;
    logic [FRAC_W-1:0]              alu_frac;
    logic                           last, upd, wr_ok;

    assign st    = note_step(5'(note_q[idx_q]));
    assign last  = idx_q == IW'(VOICES - 1);
    assign upd   = state_q == RUN && gate_q[idx_q] && int'(note_q[idx_q]) < NUM_NOTES;
    assign wr_ok = note_wr && ({1'b0, note_voice} < (IW+1)'(VOICES));

    phase_step_alu #(.PHASE_W(PHASE_W), .FRAC_W(FRAC_W), .FRAC_MOD(FRAC_MOD)) u_alu (
        .phase_i (phase_q[idx_q]),
        .frac_i  (frac_q[idx_q]),
        .step_i  (st),
        .phase_o (alu_phase),
        .frac_o  (alu_frac)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        phase_d   = phase_q;
        frac_d    = frac_q;
        note_d    = note_q;
        gate_d    = gate_q;
        overrun_d = overrun_q | (tick && state_q != IDLE);
        case (state_q)
            IDLE: begin
                state_d = tick ? RUN : IDLE;
                idx_d   = '0;
            end
            RUN: begin
                if (upd) begin
                    phase_d[idx_q] = alu_phase;
                    frac_d[idx_q]  = alu_frac;
                end
                state_d = last ? DONE : RUN;
                idx_d   = last ? idx_q : idx_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // The ALU reads note_q, so a write landing on the voice being updated only affects later ticks.
        if (wr_ok) begin
            note_d[note_voice] = note_value;
            gate_d[note_voice] = note_gate;
`ifdef HARD_SYNC_EN
            if (note_gate) begin
                phase_d[note_voice] = '0;
                frac_d[note_voice]  = '0;
            end
`endif
        end
    end

    always_comb begin
        active = '0;
        for (int v = 0; v < VOICES; v++) active[v] = gate_q[v] && int'(note_q[v]) < NUM_NOTES;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            phase_q   <= '0;
            frac_q    <= '0;
            note_q    <= '0;
            gate_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            phase_q   <= phase_d;
            frac_q    <= frac_d;
            note_q    <= note_d;
            gate_q    <= gate_d;
            overrun_q <= overrun_d;
        end
    end

    assign phase   = phase_q;
    assign busy    = state_q == RUN;
    assign done    = state_q == DONE;
    assign overrun = overrun_q;

endmodule
